// File: rtl/uart_rx_frame_if.sv
// Serial line plus deframed word, error flags and recovered bit strobe.
// The receiver uses slave; whatever drives rxd and consumes the words uses master.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 rxd;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_perr;
  logic                 rx_ferr;
  logic                 rx_busy;
  logic                 rx_bitck;
  logic                 rx_bit;

  modport slave (
    input  rxd,
    output rx_data, rx_valid, rx_perr, rx_ferr, rx_busy, rx_bitck, rx_bit
  );

  modport master (
    output rxd,
    input  rx_data, rx_valid, rx_perr, rx_ferr, rx_busy, rx_bitck, rx_bit
  );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receiver: 2-FF sync, edge re-phased bit timing, 3-vote mid-cell sampling,
// start/data/parity/stop deframing with valid pulse and parity/framing flags.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 1040,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  uart_rx_frame_if.slave  io_rx
);

  localparam int HALF   = CLKS_PER_BIT / 2;
  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int IW     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int STAGES = 2;

  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_V0   = CW'(HALF - 1);
  localparam logic [CW-1:0] C_V1   = CW'(HALF);
  localparam logic [CW-1:0] C_V2   = CW'(HALF + 1);
  localparam logic [IW-1:0] C_DLST = IW'(DATA_BITS - 1);
  localparam logic          C_SLST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK
  } state_t;

  state_t               r_state, w_nstate;
  logic [1:0]           r_sync;
  logic                 r_rs_d;
  logic [CW-1:0]        r_cnt, w_ncnt;
  logic [IW-1:0]        r_idx, w_nidx;
  logic                 r_sidx, w_nsidx;
  logic                 r_v0, r_v1;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr_acc, r_ferr_acc;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_perr, r_ferr;
  logic                 r_bitck, r_bit;
  logic [STAGES:1]      r_vld;
  logic [STAGES:0]      vld_pipe;

  logic w_rs, w_edge, w_fall, w_maj, w_in_frame, w_smp;
  logic w_early, w_late, w_wrap, w_cell_end, w_done, w_par_exp;

  assign w_rs       = r_sync[1];
  assign w_edge     = w_rs ^ r_rs_d;
  assign w_fall     = r_rs_d & ~w_rs;
  assign w_maj      = (r_v0 & r_v1) | (r_v0 & w_rs) | (r_v1 & w_rs);
  assign w_in_frame = (r_state == S_START) || (r_state == S_DATA) ||
                      (r_state == S_PAR)   || (r_state == S_STOP);
  assign w_smp      = w_in_frame && (r_cnt == C_V2);
  // Edges inside the vote window are ignored so a slow edge cannot split a vote.
  assign w_early    = w_edge && (r_cnt < C_V0);
  assign w_late     = w_edge && (r_cnt > C_V2);
  assign w_wrap     = (r_cnt == C_LAST);
  assign w_cell_end = w_in_frame && (w_wrap || w_late);
  assign w_par_exp  = (PARITY == 1) ? ~(^r_shift) : (^r_shift);
  assign vld_pipe   = {r_vld, w_done};

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt + 1'b1;
    w_nidx   = r_idx;
    w_nsidx  = r_sidx;
    w_done   = 1'b0;
    if (r_state == S_IDLE) begin
      w_ncnt = '0;
      if (w_fall) begin
        w_nstate = S_START;
        w_nidx   = '0;
        w_nsidx  = 1'b0;
      end
    end else begin
      if (w_early || w_late || w_wrap) w_ncnt = '0;
      case (r_state)
        S_START: begin
          if (w_smp && w_maj)  w_nstate = S_IDLE;
          else if (w_cell_end) w_nstate = S_DATA;
        end
        S_DATA: begin
          if (w_cell_end) begin
            if (r_idx == C_DLST) w_nstate = (PARITY != 0) ? S_PAR : S_STOP;
            else                 w_nidx   = r_idx + 1'b1;
          end
        end
        S_PAR: begin
          if (w_cell_end) w_nstate = S_STOP;
        end
        S_STOP: begin
          // The last stop bit completes the frame at its sample point, not at cell end,
          // so a following start edge may arrive half a cell early.
          if (w_smp && (r_sidx == C_SLST)) begin
            w_done   = 1'b1;
            w_nstate = w_maj ? S_IDLE : S_BREAK;
          end else if (w_cell_end) begin
            w_nsidx = 1'b1;
          end
        end
        S_BREAK: begin
          if (w_rs) w_nstate = S_IDLE;
        end
        default: w_nstate = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync  <= 2'b11;
      r_rs_d  <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sidx  <= 1'b0;
      r_v0    <= 1'b1;
      r_v1    <= 1'b1;
    end else begin
      r_sync  <= {r_sync[0], io_rx.rxd};
      r_rs_d  <= w_rs;
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_idx   <= w_nidx;
      r_sidx  <= w_nsidx;
      if (r_cnt == C_V0) r_v0 <= w_rs;
      if (r_cnt == C_V1) r_v1 <= w_rs;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_shift    <= '0;
      r_perr_acc <= 1'b0;
      r_ferr_acc <= 1'b0;
      r_bitck    <= 1'b0;
      r_bit      <= 1'b1;
    end else begin
      r_bitck <= w_smp;
      if (w_smp) r_bit <= w_maj;
      if ((r_state == S_IDLE) && w_fall) begin
        r_perr_acc <= 1'b0;
        r_ferr_acc <= 1'b0;
      end
      if (w_smp && (r_state == S_DATA)) r_shift[r_idx] <= w_maj;
      if (w_smp && (r_state == S_PAR))  r_perr_acc     <= w_maj ^ w_par_exp;
      if (w_smp && (r_state == S_STOP) && !w_maj) r_ferr_acc <= 1'b1;
    end
  end

  // Frame results leave one cycle after the flags settle; valid rides the same pipe.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_vld  <= '0;
      r_data <= '0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_vld <= vld_pipe[STAGES-1:0];
      if (vld_pipe[1]) begin
        r_data <= r_shift;
        r_perr <= (PARITY != 0) ? r_perr_acc : 1'b0;
        r_ferr <= r_ferr_acc;
      end
    end
  end

  assign io_rx.rx_data  = r_data;
  assign io_rx.rx_valid = vld_pipe[STAGES];
  assign io_rx.rx_perr  = r_perr;
  assign io_rx.rx_ferr  = r_ferr;
  assign io_rx.rx_busy  = (r_state != S_IDLE);
  assign io_rx.rx_bitck = r_bitck;
  assign io_rx.rx_bit   = r_bit;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: 8N1 receiver (a) and 8E1 receiver (b), 16 clk/bit.
module tb_uart_rx_frame;
  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n  = 1'b0;
  logic tx     = 1'b1;
  logic tx_sel = 1'b0;

  uart_rx_frame_if #(.DATA_BITS(8)) if_a ();
  uart_rx_frame_if #(.DATA_BITS(8)) if_b ();

  assign if_a.rxd = tx_sel ? 1'b1 : tx;
  assign if_b.rxd = tx_sel ? tx : 1'b1;

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .i_clk(clk), .i_rst(rst_n), .io_rx(if_a));
  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
    .i_clk(clk), .i_rst(rst_n), .io_rx(if_b));

  int       na = 0, nba = 0, nb = 0;
  logic [7:0] da = '0, db = '0;
  logic       pa = 0, fa = 0, pb = 0, fb = 0;

  always @(negedge clk) begin
    if (if_a.rx_valid) begin
      na <= na + 1; da <= if_a.rx_data; pa <= if_a.rx_perr; fa <= if_a.rx_ferr;
    end
    if (if_a.rx_bitck) nba <= nba + 1;
    if (if_b.rx_valid) begin
      nb <= nb + 1; db <= if_b.rx_data; pb <= if_b.rx_perr; fb <= if_b.rx_ferr;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int p);
    tx = b;
    cyc(p);
  endtask

  // par < 0: no parity bit; otherwise par[0] is sent. Line is left at the stop value.
  task automatic send_frame(input logic [7:0] d, input int p, input int par, input logic stp);
    send_bit(1'b0, p);
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    if (par >= 0) send_bit(par[0], p);
    send_bit(stp, p);
  endtask

  int  s_na, s_nba, s_nb;
  logic seen;

  initial begin
    cyc(5);
    chk("rst_valid", 32'(if_a.rx_valid), 0);
    chk("rst_data",  32'(if_a.rx_data),  0);
    chk("rst_perr",  32'(if_a.rx_perr),  0);
    chk("rst_ferr",  32'(if_a.rx_ferr),  0);
    chk("rst_busy",  32'(if_a.rx_busy),  0);
    chk("rst_bitck", 32'(if_a.rx_bitck), 0);
    chk("rst_bit",   32'(if_a.rx_bit),   1);
    chk("rst_b_bit", 32'(if_b.rx_bit),   1);
    rst_n = 1'b1;
    cyc(10);

    // 8N1 0xA5 at exact rate
    s_na = na; s_nba = nba;
    send_frame(8'hA5, CPB, -1, 1'b1);
    cyc(40);
    chk("t1_nvalid", 32'(na - s_na), 1);
    chk("t1_data",   32'(da), 32'h A5);
    chk("t1_perr",   32'(pa), 0);
    chk("t1_ferr",   32'(fa), 0);
    chk("t1_nbitck", 32'(nba - s_nba), 10);
    chk("t1_bit",    32'(if_a.rx_bit), 1);
    chk("t1_busy",   32'(if_a.rx_busy), 0);

    // even parity on dut_b: 0x07 has odd popcount, so the correct bit is 1
    tx_sel = 1'b1;
    cyc(5);
    s_nb = nb;
    send_frame(8'h07, CPB, 0, 1'b1);
    cyc(40);
    chk("t2a_nvalid", 32'(nb - s_nb), 1);
    chk("t2a_data",   32'(db), 32'h07);
    chk("t2a_perr",   32'(pb), 1);
    chk("t2a_ferr",   32'(fb), 0);
    send_frame(8'h07, CPB, 1, 1'b1);
    cyc(40);
    chk("t2b_nvalid", 32'(nb - s_nb), 2);
    chk("t2b_data",   32'(db), 32'h07);
    chk("t2b_perr",   32'(pb), 0);
    tx_sel = 1'b0;
    cyc(5);

    // 4-cycle start glitch
    s_na = na;
    tx = 1'b0;
    cyc(4);
    chk("t3_busy_hi", 32'(if_a.rx_busy), 1);
    tx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (!if_a.rx_busy) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t3_busy_drop", 32'(seen), 1);
    cyc(40);
    chk("t3_nvalid", 32'(na - s_na), 0);

    // stop bit low, break, then a clean frame
    s_na = na;
    send_frame(8'hF0, CPB, -1, 1'b0);
    send_bit(1'b0, 40);
    tx = 1'b1;
    cyc(20);
    chk("t4_nvalid", 32'(na - s_na), 1);
    chk("t4_ferr",   32'(fa), 1);
    chk("t4_data",   32'(da), 32'hF0);
    chk("t4_busy",   32'(if_a.rx_busy), 0);
    cyc(CPB);
    send_frame(8'h3C, CPB, -1, 1'b1);
    cyc(40);
    chk("t4b_nvalid", 32'(na - s_na), 2);
    chk("t4b_data",   32'(da), 32'h3C);
    chk("t4b_ferr",   32'(fa), 0);

    // slow transmitter, 17 clk/bit
    s_na = na;
    send_frame(8'h55, 17, -1, 1'b1);
    cyc(40);
    chk("t5_nvalid", 32'(na - s_na), 1);
    chk("t5_data",   32'(da), 32'h55);
    chk("t5_ferr",   32'(fa), 0);

    // reset in the middle of data bit 3
    s_na = na;
    send_bit(1'b0, CPB);
    send_bit(1'b1, CPB);
    send_bit(1'b1, CPB);
    send_bit(1'b1, CPB);
    tx = 1'b0;
    cyc(8);
    chk("t6_busy_pre", 32'(if_a.rx_busy), 1);
    rst_n = 1'b0;
    cyc(2);
    chk("t6_rst_busy",  32'(if_a.rx_busy),  0);
    chk("t6_rst_valid", 32'(if_a.rx_valid), 0);
    chk("t6_rst_data",  32'(if_a.rx_data),  0);
    chk("t6_rst_bitck", 32'(if_a.rx_bitck), 0);
    chk("t6_rst_bit",   32'(if_a.rx_bit),   1);
    tx = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(20);
    send_frame(8'h81, CPB, -1, 1'b1);
    cyc(40);
    chk("t6_nvalid", 32'(na - s_na), 1);
    chk("t6_data",   32'(da), 32'h81);
    chk("t6_ferr",   32'(fa), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
